// File: rtl/gold_seq_pkg.sv
// rtl/gold_seq_pkg.sv - shared types and constants for the Gold sequence sequencer
package gold_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Both generators are pre-advanced by this many bits after load.
  localparam int NC_OFFSET = 1600;

  // Fixed x1 seed: x1(0)=1, x1(1..30)=0.
  localparam logic [30:0] X1_INIT = 31'd1;

endpackage

// File: rtl/gold_word_fifo.sv
// rtl/gold_word_fifo.sv - two-entry registered FIFO holding c(n) words plus last flag
module gold_word_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   occ_q;

  // Storage, pointers and occupancy; flush empties the FIFO without touching data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      unique case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign data_o = mem_q[rd_q];
  assign occ_o  = occ_q;

  // The sequencer's credit scheme must never push into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !flush_i && occ_q == 2'd2));

endmodule

// File: rtl/gold_seq_ctrl.sv
// rtl/gold_seq_ctrl.sv - x1/x2 generator sequencer delivering c(n) words on a valid/ready stream
module gold_seq_ctrl
  import gold_seq_pkg::*;
#(
  parameter int nGenBit = 8,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [30:0]        i_c_init,
  input  logic [LEN_W-1:0]   i_num_words,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_x1_load,
  output logic               o_x1_en,
  output logic               o_x2_load,
  output logic               o_x2_en,
  output logic [30:0]        o_x2_init,
  input  logic [nGenBit-1:0] i_x1_bits,
  input  logic [nGenBit-1:0] i_x2_bits,
  output logic [nGenBit-1:0] o_c_bits,
  output logic               o_c_valid,
  input  logic               i_c_ready,
  output logic               o_c_last
);

  state_t             state_q;
  logic [LEN_W-1:0]   num_q;
  logic [LEN_W-1:0]   issued_q;
  logic [LEN_W-1:0]   delivered_q;
  logic [30:0]        c_init_q;
  logic               load_q;
  logic               done_q;
  logic               inflight_q;

  logic [1:0]         occ;
  logic               pop;
  logic               en;
  logic               flush;
  logic               push;
  logic [2:0]         credit;
  logic [LEN_W:0]     idx_in;
  logic               last_in;
  logic [nGenBit-1:0] fifo_bits;
  logic               fifo_last;

  // Generator enable is combinational on ready so a 2-entry FIFO sustains one word per cycle.
  always_comb begin
    pop     = o_c_valid && i_c_ready;
    flush   = i_abort && (state_q != IDLE);
    push    = inflight_q && !flush;
    credit  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    en      = (state_q == RUN) && !i_abort && (issued_q < num_q) && (credit < 3'd2);
    // Index of the word being pushed = words already popped + words still queued.
    idx_in  = {1'b0, delivered_q} + {{(LEN_W-1){1'b0}}, occ};
    last_in = (idx_in == ({1'b0, num_q} - (LEN_W+1)'(1)));
  end

  // Control FSM with registered load/done pulses and request counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      c_init_q    <= '0;
      load_q      <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= en;
      if (en) begin
        issued_q <= issued_q + LEN_W'(1);
      end
      if (pop) begin
        delivered_q <= delivered_q + LEN_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (i_start && !i_abort) begin
            num_q       <= i_num_words;
            c_init_q    <= i_c_init;
            issued_q    <= '0;
            delivered_q <= '0;
            if (i_num_words == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= LOAD;
              load_q  <= 1'b1;
            end
          end
        end
        LOAD: state_q <= RUN;
        RUN: begin
          if (en && (issued_q == num_q - LEN_W'(1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && fifo_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (flush) begin
        state_q     <= IDLE;
        issued_q    <= '0;
        delivered_q <= '0;
        inflight_q  <= 1'b0;
        load_q      <= 1'b0;
        done_q      <= 1'b0;
      end
    end
  end

  gold_word_fifo #(
    .W (nGenBit + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({last_in, i_x1_bits ^ i_x2_bits}),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  ({fifo_last, fifo_bits}),
    .occ_o   (occ)
  );

  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_x1_load = load_q;
  assign o_x2_load = load_q;
  assign o_x1_en   = en;
  assign o_x2_en   = en;
  assign o_x2_init = c_init_q;
  assign o_c_valid = (occ != 2'd0);
  assign o_c_bits  = fifo_bits;
  assign o_c_last  = o_c_valid && fifo_last;

endmodule
